// File: rtl/fp32_multiplier.sv
// fp32_multiplier: pipelined IEEE-754 binary32 multiplier, RNE, flush-to-zero.
// Ports: clk, rst_n (sync, active-low), in_valid/a/b in, out_valid/result out.
// Optional: define FP32_MUL_FLAGS_EN to add flags[3:0] = {invalid, overflow,
// underflow, inexact}, registered alongside result.
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
`ifdef FP32_MUL_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic [31:0] result
);

    // ---------------- stage 1: unpack, classify, multiply ----------------
    logic        w_a_ez, w_b_ez, w_a_emax, w_b_emax;
    logic        w_a_mnz, w_b_mnz;
    logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [47:0] w_prod;

    assign w_a_ez   = (a[30:23] == 8'd0);
    assign w_b_ez   = (b[30:23] == 8'd0);
    assign w_a_emax = &a[30:23];
    assign w_b_emax = &b[30:23];
    assign w_a_mnz  = |a[22:0];
    assign w_b_mnz  = |b[22:0];
    assign w_a_inf  = w_a_emax & ~w_a_mnz;
    assign w_b_inf  = w_b_emax & ~w_b_mnz;
    assign w_a_nan  = w_a_emax & w_a_mnz;
    assign w_b_nan  = w_b_emax & w_b_mnz;
    assign w_prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic signed [9:0] r_s1_exp;
    logic [47:0]       r_s1_prod;
    logic              r_s1_qnan;  // NaN input or inf x zero
    logic              r_s1_inf;
    logic              r_s1_zero;  // zero or subnormal operand
`ifdef FP32_MUL_FLAGS_EN
    logic              r_s1_sub_uf; // subnormal flushed against nonzero
`endif

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_s1_sign <= a[31] ^ b[31];
            r_s1_exp  <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
            r_s1_prod <= w_prod;
            r_s1_qnan <= w_a_nan | w_b_nan
                       | (w_a_inf & w_b_ez) | (w_b_inf & w_a_ez);
            r_s1_inf  <= w_a_inf | w_b_inf;
            r_s1_zero <= w_a_ez | w_b_ez;
`ifdef FP32_MUL_FLAGS_EN
            r_s1_sub_uf <= (w_a_ez & w_a_mnz & ~(w_b_ez & ~w_b_mnz))
                         | (w_b_ez & w_b_mnz & ~(w_a_ez & ~w_a_mnz));
`endif
        end
    end

    // ---------------- stage 2: normalize, round, pack ----------------
    logic [22:0]        w_mant;
    logic               w_g, w_r, w_st, w_up;
    logic [23:0]        w_mrnd;
    logic signed [10:0] w_exp_n, w_exp_r;
    logic               w_fin, w_ovf, w_unf;
    logic [31:0]        w_res;

    always_comb begin
        w_mant  = r_s1_prod[45:23];
        w_g     = r_s1_prod[22];
        w_r     = r_s1_prod[21];
        w_st    = |r_s1_prod[20:0];
        if (r_s1_prod[47]) begin
            w_mant = r_s1_prod[46:24];
            w_g    = r_s1_prod[23];
            w_r    = r_s1_prod[22];
            w_st   = |r_s1_prod[21:0];
        end
    end

    assign w_exp_n = {r_s1_exp[9], r_s1_exp} + {10'd0, r_s1_prod[47]};
    assign w_up    = w_g & (w_r | w_st | w_mant[0]);
    assign w_mrnd  = {1'b0, w_mant} + {23'd0, w_up};
    // All-ones mantissa rounding up carries into the exponent; the
    // mantissa field is already zero in that case.
    assign w_exp_r = w_exp_n + {10'd0, w_mrnd[23]};

    assign w_fin = ~r_s1_qnan & ~r_s1_inf & ~r_s1_zero;
    assign w_ovf = w_fin & (w_exp_r >= 11'sd255);
    assign w_unf = w_fin & (w_exp_r <= 11'sd0);

    always_comb begin
        w_res = {r_s1_sign, w_exp_r[7:0], w_mrnd[22:0]};
        if (r_s1_qnan)
            w_res = 32'h7FC0_0000;
        else if (r_s1_inf || w_ovf)
            w_res = {r_s1_sign, 8'hFF, 23'd0};
        else if (r_s1_zero || w_unf)
            w_res = {r_s1_sign, 31'd0};
    end

`ifdef FP32_MUL_FLAGS_EN
    logic [3:0] w_flg;
    logic       w_uf_all;
    assign w_uf_all = w_unf
                    | (~r_s1_qnan & ~r_s1_inf & r_s1_zero & r_s1_sub_uf);
    assign w_flg = {r_s1_qnan, w_ovf, w_uf_all,
                    w_ovf | w_uf_all
                    | (w_fin & ~w_ovf & ~w_unf & (w_g | w_r | w_st))};
    logic [3:0] r_s2_flg;
`endif

    logic        r_s2_valid;
    logic [31:0] r_s2_res;

    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_s2_res <= w_res;
`ifdef FP32_MUL_FLAGS_EN
            r_s2_flg <= w_flg;
`endif
        end
    end

    // ---------------- valid chain and output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            result     <= 32'h0000_0000;
`ifdef FP32_MUL_FLAGS_EN
            flags      <= 4'd0;
`endif
        end else begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                result <= r_s2_res;
`ifdef FP32_MUL_FLAGS_EN
                flags  <= r_s2_flg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed-vector bench for fp32_multiplier.
// Streams hand-computed vectors back-to-back, then checks hold and reset.
module tb_fp32_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;
`ifdef FP32_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    always #5 clk = ~clk;

    fp32_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
`ifdef FP32_MUL_FLAGS_EN
        .flags     (flags),
`endif
        .result    (result)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    localparam int NV = 15;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];
    logic [3:0]  vf [NV];

    initial begin
        va = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h3F800001, 32'h3FFFFFFF, 32'h3F7FFFFF,
               32'h7F7FFFFF, 32'h00800000, 32'h00000001, 32'h7F800000,
               32'hFF800000, 32'h7FC00001, 32'h80000000};
        vb = '{32'h40000000, 32'h40800000, 32'h3F800000, 32'h00000000,
               32'hBF800000, 32'h3F800001, 32'h3FFFFFFF, 32'h3F800001,
               32'h40000000, 32'h3F000000, 32'h7F7FFFFF, 32'h00000000,
               32'h40000000, 32'h3F800000, 32'h3F800000};
        vr = '{32'h40000000, 32'h41400000, 32'h3F800000, 32'h00000000,
               32'hBF800000, 32'h3F800002, 32'h407FFFFE, 32'h3F800000,
               32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
               32'hFF800000, 32'h7FC00000, 32'h80000000};
        vf = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b0000, 4'b0001, 4'b0001, 4'b0001,
               4'b0101, 4'b0011, 4'b0011, 4'b1000,
               4'b0000, 4'b1000, 4'b0000};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
`ifdef FP32_MUL_FLAGS_EN
        chk("rst_flags", {28'd0, flags}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV + 3; k++) begin
            logic ev;
            @(negedge clk);
            if (k < NV) begin
                in_valid = 1'b1;
                a        = va[k];
                b        = vb[k];
            end else begin
                in_valid = 1'b0;
                a        = '0;
                b        = '0;
            end
            @(posedge clk);
            #1;
            ev = (k >= 2) && (k - 2 < NV);
            chk($sformatf("valid_c%0d", k), {31'd0, out_valid},
                {31'd0, ev});
            if (ev) begin
                chk($sformatf("res_v%0d", k - 2), result, vr[k-2]);
`ifdef FP32_MUL_FLAGS_EN
                chk($sformatf("flg_v%0d", k - 2), {28'd0, flags},
                    {28'd0, vf[k-2]});
`endif
            end
        end

        @(negedge clk);
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_result", result, 32'h80000000);

        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h40400000;
        b        = 32'h40800000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mrst_valid%0d", k), {31'd0, out_valid}, 32'd0);
            chk($sformatf("mrst_res%0d", k), result, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fp32_multiplier.md
Name: fp32_multiplier

Overview:
- Pipelined IEEE-754 binary32 multiplier: result = a × b, rounded to nearest, ties to even.
- Two-cycle latency, fully pipelined, one new operand pair accepted per clock.
- Arithmetic leaf block for datapath units. Valid-tagged, with no backpressure.

Parameters:
- none (format fixed to binary32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- out_valid  output  1  result valid
- result  output  32  product, binary32

Behaviour:
- One clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: result=32'h0000_0000, out_valid=0. All pipeline valid bits are cleared.
- Reset asserted mid-operation discards all in-flight operations; no out_valid pulse follows.
- Latency:
  - in_valid=1 sampled at edge N gives out_valid=1 with the matching result after edge N+2.
  - Back-to-back inputs give back-to-back outputs, in order.
- When out_valid=0, result holds its last value. Pipeline registers load only when their stage valid is 1.
- Stage 1 (registered):
  - Unpack fields. Sign = sa ^ sb.
  - Exponent sum ea + eb − 127, kept as a 10-bit signed value.
  - 24×24 significand product with hidden bits, 48 bits wide.
  - Classify each operand as zero, subnormal, inf, NaN or normal.
- Stage 2 (registered):
  - Normalize: if product bit 47 is set, shift right 1 and increment the exponent.
  - Form guard, round and sticky bits. Round to nearest even.
  - A rounding carry-out renormalizes and increments the exponent again.
- Subnormal handling (flush-to-zero):
  - Subnormal inputs are treated as signed zero.
  - If the final biased exponent is ≤ 0, the result is signed zero.
- Overflow: a final biased exponent ≥ 255 gives signed infinity (exponent 0xFF, mantissa 0).
- Special-case priority, highest first:
  - Any NaN input gives canonical qNaN 32'h7FC0_0000.
  - Inf × zero gives 32'h7FC0_0000.
  - Inf × (finite nonzero or inf) gives signed infinity.
  - Zero × finite gives signed zero (sign = sa ^ sb, e.g. −0 for 1.0 × −0.0).
- NaN sign and payload are not propagated.

Optional Feature:
- Macro: FP32_MUL_FLAGS_EN.
- When defined, add output port flags [3:0] = {invalid, overflow, underflow, inexact}.
  - Registered alongside result and valid with out_valid. Reset value 0.
  - invalid: NaN input, or inf × zero.
  - overflow: rounded result became infinity from finite operands; inexact is also set.
  - underflow: nonzero exact result flushed to zero, including subnormal input with a nonzero other operand; inexact is also set.
  - inexact: any of the guard, round or sticky bits were nonzero, or overflow/underflow occurred.
- When undefined, the port and its logic are absent. Result behaviour is identical either way.

Test Plan:
- Reset, then five back-to-back valid pairs, with out_valid checked exactly 2 cycles after each input:
  - 3F800000×40000000 → 40000000
  - 40400000×40800000 → 41400000
  - 3F800000×3F800000 → 3F800000
  - 3F800000×00000000 → 00000000
  - 3F800000×BF800000 → BF800000
- Rounding:
  - 3F800001×3F800001 → 3F800002 (RNE).
  - 3FFFFFFF×3FFFFFFF → 407FFFFE.
  - Carry-out case 3F7FFFFF×3F800001 → 3F800000.
- Specials:
  - 7F800000×00000000 → 7FC00000.
  - FF800000×40000000 → FF800000.
  - 7FC00001×3F800000 → 7FC00000.
  - 80000000×3F800000 → 80000000.
- Range:
  - Overflow 7F7FFFFF×40000000 → 7F800000.
  - Flush 00800000×3F000000 → 00000000.
  - Subnormal input 00000001×7F7FFFFF → 00000000.
- Reset mid-flight: in_valid pulse, then rst_n=0 on the next edge → out_valid stays 0 and result=0.
- With FP32_MUL_FLAGS_EN:
  - Overflow case → flags=4'b0101.
  - Inf×0 → 4'b1000.
  - 1.0×2.0 → 4'b0000.
